// File: rtl/lfsr_stim_gen_pkg.sv
// rtl/lfsr_stim_gen_pkg.sv - shared types, constants and LFSR step function for the stimulus generator
package stim_pkg;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} stim_state_t;

  localparam int          LFSR_TAPS [4] = '{31, 21, 1, 0};
  localparam logic [31:0] DEFAULT_SEED  = 32'hACE1_2468;

  // Fibonacci form: shift left, feedback enters at bit 0.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    logic fb;
    fb = s[LFSR_TAPS[0]] ^ s[LFSR_TAPS[1]] ^ s[LFSR_TAPS[2]] ^ s[LFSR_TAPS[3]];
    return {s[30:0], fb};
  endfunction

endpackage

// File: rtl/lfsr_stim_gen_lfsr32.sv
// rtl/lfsr_stim_gen_lfsr32.sv - 32-bit LFSR state register with load and advance
module lfsr32
  import stim_pkg::*;
(
  input  logic        clk,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        advance,
  output logic [31:0] state
);

  logic [31:0] state_q;
  logic [31:0] state_d;

  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = seed;
    end else if (advance) begin
      state_d = lfsr_step(state_q);
    end
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
  end

  assign state = state_q;

endmodule

// File: rtl/lfsr_stim_gen.sv
// rtl/lfsr_stim_gen.sv - pseudo-random write stimulus source with back-pressure
// Optional random gap cycles enabled by LFSR_STIM_GAP_EN.
module lfsr_stim_gen
  import stim_pkg::*;
#(
  parameter int          DATA_WIDTH = 16,
  parameter logic [31:0] SEED       = DEFAULT_SEED,
  parameter int          NUM_TXN    = 64,
  parameter int          DELAY_BITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  queue_full,
  output logic                  wen,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [15:0]           delay,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           txn_count
);

  localparam logic [31:0] SEED_EFF  = (SEED == 32'h0) ? 32'h1 : SEED;
  localparam logic [15:0] NUM_TXN_W = 16'(NUM_TXN);

  stim_state_t state_q;
  logic [15:0] txn_count_q;
  logic [15:0] txn_count_d;
  logic        busy_q;
  logic        done_q;
  logic [31:0] lfsr_state;
  logic        run_ok;
  logic        gap;
  logic        wr;
  logic        unused_lfsr;

  // Gated by rst so nothing transfers on the reset cycle.
  assign run_ok = (state_q == S_RUN) && !queue_full && !rst;

`ifdef LFSR_STIM_GAP_EN
  assign gap = lfsr_state[30];
`else
  assign gap = 1'b0;
`endif

  assign wr          = run_ok && !gap;
  assign txn_count_d = txn_count_q + 16'd1;

  // A gap cycle still consumes an LFSR value, so the LFSR follows run_ok, not wr.
  lfsr32 u_lfsr (
    .clk     (clk),
    .load    (rst),
    .seed    (SEED_EFF),
    .advance (run_ok),
    .state   (lfsr_state)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      txn_count_q <= 16'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            txn_count_q <= 16'd0;
            if (NUM_TXN_W == 16'd0) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_RUN;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
            end
          end
        end
        S_RUN: begin
          if (wr) begin
            txn_count_q <= txn_count_d;
            if (txn_count_d == NUM_TXN_W) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign wen         = wr;
  assign data_out    = lfsr_state[DATA_WIDTH-1:0];
  assign delay       = 16'(lfsr_state[31 -: DELAY_BITS]);
  assign busy        = busy_q;
  assign done        = done_q;
  assign txn_count   = txn_count_q;
  assign unused_lfsr = ^lfsr_state;

endmodule

// File: tb/tb_lfsr_stim_gen.sv
// tb/tb_lfsr_stim_gen.sv - self-checking bench for lfsr_stim_gen against a stream-index reference model
module tb_lfsr_stim_gen;

  localparam int DW = 16;
  localparam int NT = 4;

`ifdef LFSR_STIM_GAP_EN
  localparam bit GAP = 1'b1;
`else
  localparam bit GAP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, start, queue_full;
  logic          wen, busy, done;
  logic [DW-1:0] data_out;
  logic [15:0]   delay, txn_count;
  logic          z_wen, z_busy, z_done;
  logic [DW-1:0] z_data_out;
  logic [15:0]   z_delay, z_txn_count;

  always #5 clk = ~clk;

  lfsr_stim_gen #(.DATA_WIDTH(DW), .SEED(32'h1), .NUM_TXN(NT), .DELAY_BITS(3)) dut (
    .clk(clk), .rst(rst), .start(start), .queue_full(queue_full),
    .wen(wen), .data_out(data_out), .delay(delay), .busy(busy), .done(done),
    .txn_count(txn_count)
  );

  lfsr_stim_gen #(.DATA_WIDTH(DW), .SEED(32'h1), .NUM_TXN(0), .DELAY_BITS(3)) dut_zero (
    .clk(clk), .rst(rst), .start(start), .queue_full(queue_full),
    .wen(z_wen), .data_out(z_data_out), .delay(z_delay), .busy(z_busy), .done(z_done),
    .txn_count(z_txn_count)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: the whole LFSR stream from the seed, plus an index into it.
  logic [31:0] stream [4096];
  int          m_mode;   // 0 idle, 1 run, 2 done
  int          m_cnt;
  int          m_pos;
  bit          z_exp_done;

  function automatic logic [31:0] next_val(input logic [31:0] s);
    int ones;
    ones = $countones(s & 32'h8020_0003);
    return (s << 1) | 32'(ones % 2);
  endfunction

  task automatic check_outputs();
    logic [31:0] cur;
    bit          gap;
    cur = stream[m_pos];
    gap = GAP && cur[30];
    check_val("wen", 32'(wen), 32'((m_mode == 1) && !queue_full && !gap && !rst));
    check_val("data_out", 32'(data_out), 32'(cur[DW-1:0]));
    check_val("delay", 32'(delay), 32'(cur[31:29]));
    check_val("busy", 32'(busy), 32'(m_mode == 1));
    check_val("done", 32'(done), 32'(m_mode == 2));
    check_val("txn_count", 32'(txn_count), 32'(m_cnt));
    check_val("zero_wen", 32'(z_wen), 32'(0));
    check_val("zero_done", 32'(z_done), 32'(z_exp_done));
  endtask

  task automatic model_update();
    logic [31:0] cur;
    bit          gap;
    cur = stream[m_pos];
    gap = GAP && cur[30];
    if (rst) begin
      m_mode = 0; m_cnt = 0; m_pos = 0; z_exp_done = 1'b0;
    end else begin
      if (start) z_exp_done = 1'b1;
      if (m_mode == 1) begin
        if (!queue_full) begin
          m_pos++;
          if (!gap) begin
            m_cnt++;
            if (m_cnt == NT) m_mode = 2;
          end
        end
      end else if (start) begin
        m_cnt  = 0;
        m_mode = 1;
      end
    end
  endtask

  // Caller is at a negedge; checks, advances the model, lands at posedge+1.
  task automatic step();
    check_outputs();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    @(negedge clk);
    step();
  endtask

  logic [15:0] exp1 [4];
  logic [15:0] bp_data [7];
  logic        bp_full [7];

  initial begin
    stream[0] = 32'h1;
    for (int i = 1; i < 4096; i++) stream[i] = next_val(stream[i-1]);
    exp1 = '{16'h0001, 16'h0003, 16'h0006, 16'h000D};
    bp_data = '{16'h0001, 16'h0003, 16'h0003, 16'h0003, 16'h0003, 16'h0006, 16'h000D};
    bp_full = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    rst = 1'b1; start = 1'b0; queue_full = 1'b0;
    @(posedge clk); #1;
    m_mode = 0; m_cnt = 0; m_pos = 0; z_exp_done = 1'b0;
    rst = 1'b0;

    // Reset state and a clean 4-write run.
    @(negedge clk);
    check_val("rst_busy", 32'(busy), 32'(0));
    check_val("rst_done", 32'(done), 32'(0));
    check_val("rst_count", 32'(txn_count), 32'(0));
    check_val("rst_data", 32'(data_out), 32'h1);
    check_val("rst_wen", 32'(wen), 32'(0));
    step();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_val("s1_wen", 32'(wen), 32'(1));
      check_val("s1_data", 32'(data_out), 32'(exp1[k]));
      check_val("s1_delay", 32'(delay), 32'(0));
      if (k == 0) check_val("s1_zero_done", 32'(z_done), 32'(1));
      step();
    end
    @(negedge clk);
    check_val("s1_done", 32'(done), 32'(1));
    check_val("s1_count", 32'(txn_count), 32'(4));
    check_val("s1_wen_after", 32'(wen), 32'(0));
    step();

    // Restart from DONE continues the stream.
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    check_val("rs_count", 32'(txn_count), 32'(0));
    check_val("rs_data", 32'(data_out), 32'h1B);
    step();
    for (int k = 0; k < 4; k++) tick();

    // Back-pressure on run cycles 2..4.
    rst = 1'b1; tick(); rst = 1'b0; tick();
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 0; c < 7; c++) begin
      queue_full = bp_full[c];
      @(negedge clk);
      check_val("bp_wen", 32'(wen), 32'(!bp_full[c]));
      check_val("bp_data", 32'(data_out), 32'(bp_data[c]));
      step();
    end
    queue_full = 1'b0;
    @(negedge clk);
    check_val("bp_done", 32'(done), 32'(1));
    step();

    // Reset after two writes.
    rst = 1'b1; tick(); rst = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    rst = 1'b1;
    @(negedge clk);
    check_val("mr_wen", 32'(wen), 32'(0));
    step();
    rst = 1'b0;
    @(negedge clk);
    check_val("mr_busy", 32'(busy), 32'(0));
    check_val("mr_count", 32'(txn_count), 32'(0));
    check_val("mr_data", 32'(data_out), 32'h1);
    step();
    start = 1'b1; tick(); start = 1'b0;
    @(negedge clk);
    check_val("mr_data0", 32'(data_out), 32'h1);
    step();
    @(negedge clk);
    check_val("mr_data1", 32'(data_out), 32'h3);
    step();
    for (int k = 0; k < 3; k++) tick();

    // Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      rst        = ($urandom_range(0, 99) == 0);
      start      = ($urandom_range(0, 9) == 0);
      queue_full = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lfsr_stim_gen.md
# lfsr_stim_gen

- Upstream stimulus source for the run environment.
- Drives a pseudo-random stream of write transactions into an `rw_queue` write port (`wen`, `data_in`, `queue_full`).
- Also presents a per-transaction random `delay` for a parallel `timed_queue`.
- Issues exactly `NUM_TXN` writes per run, respects queue back-pressure, and is fully reproducible from `SEED`.

## Interface
Parameters:
- `DATA_WIDTH`, 16: width of `data_out`; legal range 1..32.
- `SEED`, 32'hACE1_2468: LFSR load value on reset; 0 is replaced by 32'h1.
- `NUM_TXN`, 64: writes per run; legal range 0..65535.
- `DELAY_BITS`, 3: number of LFSR bits used for `delay`; legal range 1..8.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: begin a run; sampled in IDLE and DONE only.
- `queue_full` in 1: back-pressure from the downstream `rw_queue`.
- `wen` out 1: write strobe; a transaction transfers on any cycle with `wen`=1.
- `data_out` out DATA_WIDTH: transaction payload, `lfsr[DATA_WIDTH-1:0]`.
- `delay` out 16 (shortint unsigned): zero-extended `lfsr[31 -: DELAY_BITS]`.
- `busy` out 1: high in RUN.
- `done` out 1: high in DONE.
- `txn_count` out 16: writes issued in the current run.

## Operation
- LFSR: 32-bit Fibonacci.
  - `fb = lfsr[31]^lfsr[21]^lfsr[1]^lfsr[0]`.
  - `next = {lfsr[30:0], fb}`.
  - Advances only on write cycles, or on gap cycles (see Configuration).
- FSM states: IDLE, RUN, DONE.
  - IDLE, `start`=1: go to RUN with `txn_count`←0. If `NUM_TXN`==0, go to DONE instead.
  - RUN: `wen = ~queue_full` (gated further by the gap feature).
    - On each write, `txn_count`++.
    - The write that makes `txn_count`==`NUM_TXN` moves the FSM to DONE on the same edge.
  - DONE: `done` is held. `start`=1 moves to RUN with `txn_count`←0. The LFSR is not reseeded, so the stream continues.
  - `start` in RUN is ignored.
- `queue_full`=1 in RUN: no write; LFSR, `data_out`, `delay` and `txn_count` all hold.
- Counter arithmetic is unsigned 16-bit and never wraps, because `NUM_TXN` ≤ 65535.

## Timing
- Reset values: state IDLE, `lfsr`=SEED (or 1 if SEED is 0), `wen`=0, `busy`=0, `done`=0, `txn_count`=0.
  - `data_out` and `delay` reflect the seed.
- Reset mid-run aborts immediately. No write occurs on the reset cycle.
- `rst` dominates `start`.
- `wen` is a combinational function of the registered state and `queue_full`. This is required for same-cycle back-pressure, so there must be no overflow of the `rw_queue`.
  - All other outputs are registered.
- First write is possible on the cycle after `start` is sampled, giving start-to-`wen` latency of 1.
- With no back-pressure and no gaps, a run takes `NUM_TXN` consecutive cycles. `done` rises on the cycle after the last `wen`.

## Configuration
- Macro `LFSR_STIM_GAP_EN`.
- Defined:
  - In RUN, if `lfsr[30]`=1, the cycle is a gap: `wen`=0 and the LFSR still advances. The next payload therefore differs from the skipped one.
  - `txn_count` holds on a gap cycle.
  - A gap cycle with `queue_full`=1 does not advance the LFSR.
- Undefined: a write is issued on every RUN cycle with `queue_full`=0, and `lfsr[30]` is ignored.

## Structure
- Package `stim_pkg`:
  - `typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} stim_state_t`.
  - `LFSR_TAPS` constant (31, 21, 1, 0).
  - `DEFAULT_SEED`.
  - Function `lfsr_step`.
- One sub-module, `lfsr32`: holds the state register, with `load`, `seed` and `advance` inputs and a 32-bit `state` output.
  - FSM and counter live in `lfsr_stim_gen`.

## Test plan
- Reset + LFSR stream (`SEED`=1, `NUM_TXN`=4, `queue_full`=0): pulse `start` → `wen` high for 4 cycles.
  - `data_out` sequence is 0x0001, 0x0003, 0x0006, 0x000D; `delay`=0 each time.
  - `done`=1 and `txn_count`=4 after the last write.
- Back-pressure (`SEED`=1, `NUM_TXN`=4): hold `queue_full`=1 for cycles 2–4 of the run.
  - `wen` is 0 throughout the hold, and `data_out` stays 0x0003.
  - All 4 writes still complete, with values identical to the first scenario.
- `NUM_TXN`=0: `start` → `done`=1 next cycle; `wen` never asserts.
- Mid-run reset: assert `rst` after 2 writes.
  - Next cycle: IDLE, `txn_count`=0, `data_out`=0x0001.
  - A new `start` reproduces 0x0001, 0x0003, ….
- Restart from DONE: `start` after the first scenario gives `txn_count` restarting at 0, with the stream continuing at 0x001B (not reseeded).
- With `LFSR_STIM_GAP_EN` and `SEED`=32'h4000_0000: the first RUN cycle has `wen`=0, and the LFSR still advances to 32'h8000_0000.
